// File: rtl/prog_loader.sv
// Boot-image loader: waits for a sync byte, takes a word count, assembles bytes
// MSB-first into 32-bit words for instruction memory, then verifies an XOR checksum.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    count_n;
    logic [7:0]    word_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shift_reg;
    logic [7:0]    csum;
    logic [IW-1:0] idle_cnt;

    logic accept;
    logic loading;
    logic timeout_hit;
    logic last_byte;
    logic last_word;

    // Handshake: a byte transfers on a clk1 edge only when rx_valid and rx_ready are both high.
    assign rx_ready    = (state == S_IDLE) || (state == S_COUNT) ||
                         (state == S_DATA) || (state == S_CHECK);
    assign accept      = rx_valid && rx_ready;
    assign loading     = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    assign timeout_hit = loading && !accept && (idle_cnt == IDLE_LIMIT);
    assign last_byte   = (byte_idx == 2'd3);
    assign last_word   = (word_idx == count_n - 8'd1);

    assign done     = (state == S_DONE);
    assign err      = (state == S_ERROR);
    assign cpu_hold = (state != S_DONE);

    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (accept) state_nxt = (rx_data == 8'd0) ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (accept && last_byte && last_word) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
            end
            default: state_nxt = state;
        endcase
        if (timeout_hit) state_nxt = S_ERROR;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            count_n   <= 8'd0;
            word_idx  <= 8'd0;
            byte_idx  <= 2'd0;
            shift_reg <= 32'd0;
            csum      <= 8'd0;
            idle_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 32'd0;
        end else begin
            wr_en <= 1'b0;

            if (loading && !accept) begin
                idle_cnt <= idle_cnt + IW'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (state == S_COUNT && accept) begin
                count_n   <= rx_data;
                word_idx  <= 8'd0;
                byte_idx  <= 2'd0;
                shift_reg <= 32'd0;
                csum      <= 8'd0;
            end

            // The 4th byte of a word completes it and issues the write on the same edge.
            if (state == S_DATA && accept) begin
                shift_reg <= {shift_reg[23:0], rx_data};
                csum      <= csum ^ rx_data;
                byte_idx  <= byte_idx + 2'd1;
                if (last_byte) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= word_idx;
                    wr_data  <= {shift_reg[23:0], rx_data};
                    word_idx <= word_idx + 8'd1;
                end
            end
        end
    end

endmodule
